// File: rtl/cp0_irq_unit_if.sv
// Bus between the M-stage datapath and the coprocessor-0 / interrupt unit.
// The datapath side is the master; the cp0 unit is the slave.
interface cp0_irq_unit_if #(
  parameter int NUM_HWINT = 6
) ();
  logic [4:0]           A1;
  logic [31:0]          RD;
  logic [4:0]           A2;
  logic [31:0]          WD;
  logic                 WE;
  logic [31:0]          PC;
  logic                 BD;
  logic                 ExcValid;
  logic [4:0]           ExcCode;
  logic                 EXLClr;
  logic [NUM_HWINT-1:0] HWInt;
  logic                 Req;
  logic [31:0]          EPC;

  modport master (
    output A1, A2, WD, WE, PC, BD, ExcValid, ExcCode, EXLClr, HWInt,
    input  RD, Req, EPC
  );

  modport slave (
    input  A1, A2, WD, WE, PC, BD, ExcValid, ExcCode, EXLClr, HWInt,
    output RD, Req, EPC
  );
endinterface

// File: rtl/cp0_irq_unit.sv
// Coprocessor-0 / interrupt controller for the pipelined MIPS core.
// Holds SR, Cause, EPC and PRId, raises Req for interrupts or synchronous
// exceptions of the M-stage instruction, and tracks handler state (EXL).
// Pending interrupts either follow the lines (level) or latch on rising
// edges until software clears them through a Cause write (edge).
module cp0_irq_unit #(
  parameter int          NUM_HWINT = 6,
  parameter bit          INT_LATCH = 1'b0,
  parameter logic [31:0] PRID      = 32'h2019_0701
) (
  input logic           Clk,
  input logic           Reset,
  cp0_irq_unit_if.slave bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 ie_r;
  logic [NUM_HWINT-1:0] im_r;
  logic                 bd_r;
  logic [4:0]           exccode_r;
  logic [NUM_HWINT-1:0] ip_r;
  logic [31:0]          epc_r;

  logic                 exl_s;
  logic                 int_req_s;
  logic                 exc_req_s;
  logic                 req_s;
  logic                 sr_wr_s;
  logic                 epc_wr_s;
  logic [31:0]          epc_entry_s;
  logic [31:0]          sr_s;
  logic [31:0]          cause_s;
  logic [31:0]          rd_s;

  // Request generation and mtc0 qualification; any mtc0 in a Req cycle is dropped.
  always_comb begin
    exl_s     = (state_r == ST_HANDLER);
    int_req_s = ie_r & ~exl_s & (|(ip_r & im_r));
    exc_req_s = bus.ExcValid & ~exl_s;
    req_s     = int_req_s | exc_req_s;
    sr_wr_s   = bus.WE & (bus.A2 == REG_SR) & ~req_s;
    epc_wr_s  = bus.WE & (bus.A2 == REG_EPC) & ~req_s;
    if (bus.BD) begin
      epc_entry_s = (bus.PC - 32'd4) & 32'hFFFF_FFFC;
    end else begin
      epc_entry_s = bus.PC & 32'hFFFF_FFFC;
    end
  end

  // Next-state logic: entry beats eret, eret beats an mtc0 to SR.EXL.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_NORMAL: begin
        if (req_s) begin
          state_nxt_s = ST_HANDLER;
        end else if (bus.EXLClr) begin
          state_nxt_s = ST_NORMAL;
        end else if (sr_wr_s && bus.WD[1]) begin
          state_nxt_s = ST_HANDLER;
        end else begin
          state_nxt_s = ST_NORMAL;
        end
      end
      ST_HANDLER: begin
        if (bus.EXLClr) begin
          state_nxt_s = ST_NORMAL;
        end else if (sr_wr_s && !bus.WD[1]) begin
          state_nxt_s = ST_NORMAL;
        end else begin
          state_nxt_s = ST_HANDLER;
        end
      end
      default: state_nxt_s = ST_NORMAL;
    endcase
  end

  // Handler state register (this is SR.EXL).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_NORMAL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // SR.IE/IM, Cause.BD/ExcCode and EPC: reset, then exception entry, then mtc0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ie_r      <= 1'b0;
      im_r      <= {NUM_HWINT{1'b0}};
      bd_r      <= 1'b0;
      exccode_r <= 5'd0;
      epc_r     <= 32'h0000_0000;
    end else if (req_s) begin
      bd_r      <= bus.BD;
      exccode_r <= int_req_s ? 5'd0 : bus.ExcCode;
      epc_r     <= epc_entry_s;
    end else begin
      if (sr_wr_s) begin
        ie_r <= bus.WD[0];
        im_r <= bus.WD[10 +: NUM_HWINT];
      end
      if (epc_wr_s) begin
        epc_r <= {bus.WD[31:2], 2'b00};
      end
    end
  end

  generate
    if (INT_LATCH) begin : g_edge
      logic [NUM_HWINT-1:0] prev_r;
      logic [NUM_HWINT-1:0] clr_s;

      // Software clear mask: a zero written to a Cause.IP bit clears it.
      always_comb begin
        if (bus.WE && (bus.A2 == REG_CAUSE) && !req_s) begin
          clr_s = ~bus.WD[10 +: NUM_HWINT];
        end else begin
          clr_s = {NUM_HWINT{1'b0}};
        end
      end

      // Sticky pending bits; a new rising edge wins over a same-cycle clear.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          prev_r <= {NUM_HWINT{1'b0}};
          ip_r   <= {NUM_HWINT{1'b0}};
        end else begin
          prev_r <= bus.HWInt;
          ip_r   <= (ip_r & ~clr_s) | (bus.HWInt & ~prev_r);
        end
      end
    end else begin : g_level
      // Pending bits follow the interrupt lines with one cycle of latency.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          ip_r <= {NUM_HWINT{1'b0}};
        end else begin
          ip_r <= bus.HWInt;
        end
      end
    end
  endgenerate

  // Register images and the mfc0 read mux (no bypass of same-cycle writes).
  always_comb begin
    sr_s                     = 32'h0000_0000;
    sr_s[10 +: NUM_HWINT]    = im_r;
    sr_s[1]                  = exl_s;
    sr_s[0]                  = ie_r;
    cause_s                  = 32'h0000_0000;
    cause_s[31]              = bd_r;
    cause_s[10 +: NUM_HWINT] = ip_r;
    cause_s[6:2]             = exccode_r;
    case (bus.A1)
      REG_SR:    rd_s = sr_s;
      REG_CAUSE: rd_s = cause_s;
      REG_EPC:   rd_s = epc_r;
      REG_PRID:  rd_s = PRID;
      default:   rd_s = 32'h0000_0000;
    endcase
  end

  assign bus.RD  = rd_s;
  assign bus.Req = req_s;
  assign bus.EPC = epc_r;

endmodule

// File: tb/tb_cp0_irq_unit.sv
// Self-checking bench for cp0_irq_unit: one level-mode and one edge-mode
// instance share clock and reset. Expected values are queued when stimulus
// is applied and popped when the matching output is sampled.
module tb_cp0_irq_unit;
  localparam logic [31:0] PRID_C = 32'h2019_0701;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cp0_irq_unit_if #(.NUM_HWINT(6)) b_l ();
  cp0_irq_unit_if #(.NUM_HWINT(6)) b_e ();

  cp0_irq_unit #(.NUM_HWINT(6), .INT_LATCH(1'b0), .PRID(PRID_C)) u_lvl (
    .Clk(clk), .Reset(rst), .bus(b_l)
  );
  cp0_irq_unit #(.NUM_HWINT(6), .INT_LATCH(1'b1), .PRID(PRID_C)) u_edg (
    .Clk(clk), .Reset(rst), .bus(b_e)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b_l.A1 = 5'd0; b_l.A2 = 5'd0; b_l.WD = 32'h0; b_l.WE = 1'b0;
    b_l.PC = 32'h0; b_l.BD = 1'b0; b_l.ExcValid = 1'b0; b_l.ExcCode = 5'd0;
    b_l.EXLClr = 1'b0; b_l.HWInt = 6'h00;
    b_e.A1 = 5'd0; b_e.A2 = 5'd0; b_e.WD = 32'h0; b_e.WE = 1'b0;
    b_e.PC = 32'h0; b_e.BD = 1'b0; b_e.ExcValid = 1'b0; b_e.ExcCode = 5'd0;
    b_e.EXLClr = 1'b0; b_e.HWInt = 6'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; b_l.HWInt = 6'h3F; b_e.HWInt = 6'h3F;
    tick(); tick();
    rst = 1'b0; b_l.HWInt = 6'h00; b_e.HWInt = 6'h00;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(PRID_C);
    for (int i = 12; i < 16; i++) begin
      b_l.A1 = 5'(i);
      #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (b_l.RD !== exp_v) begin
        n_fail++; $display("FAIL reset_rd A1=%0d got %h expected %h", i, b_l.RD, exp_v);
      end
    end
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL reset_req_lvl got %b expected %h", b_l.Req, exp_v);
    end
    b_e.A1 = 5'd15; #1;
    exp_q.push_back(PRID_C);
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_e.RD !== exp_v) begin
      n_fail++; $display("FAIL reset_prid_edge got %h expected %h", b_e.RD, exp_v);
    end
  endtask

  task automatic test_level_irq();
    b_l.WE = 1'b1; b_l.A2 = 5'd12; b_l.WD = 32'h0000_0401;
    tick();
    b_l.WE = 1'b0; b_l.WD = 32'h0; b_l.HWInt = 6'h01;
    exp_q.push_back(32'h0); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL lvl_latency_req got %b expected %h", b_l.Req, exp_v);
    end
    tick();
    b_l.PC = 32'h0000_3010; b_l.BD = 1'b0;
    exp_q.push_back(32'h1); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL lvl_req got %b expected %h", b_l.Req, exp_v);
    end
    tick();
    exp_q.push_back(32'h0000_3010); exp_q.push_back(32'h0000_0400);
    exp_q.push_back(32'h0000_0403); exp_q.push_back(32'h0);
    b_l.A1 = 5'd13; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.EPC !== exp_v) begin
      n_fail++; $display("FAIL lvl_epc got %h expected %h", b_l.EPC, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL lvl_cause got %h expected %h", b_l.RD, exp_v);
    end
    b_l.A1 = 5'd12; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL lvl_sr got %h expected %h", b_l.RD, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL lvl_handler_req got %b expected %h", b_l.Req, exp_v);
    end
  endtask

  task automatic test_eret();
    b_l.EXLClr = 1'b1;
    exp_q.push_back(32'h0); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL eret_cycle_req got %b expected %h", b_l.Req, exp_v);
    end
    tick();
    b_l.EXLClr = 1'b0; b_l.A1 = 5'd12;
    exp_q.push_back(32'h0000_0401); exp_q.push_back(32'h1); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL eret_sr got %h expected %h", b_l.RD, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL eret_reassert_req got %b expected %h", b_l.Req, exp_v);
    end
  endtask

  task automatic test_simultaneous();
    b_l.BD = 1'b1; b_l.PC = 32'h0000_3020;
    b_l.ExcValid = 1'b1; b_l.ExcCode = 5'd12;
    b_l.WE = 1'b1; b_l.A2 = 5'd14; b_l.WD = 32'h0000_1234;
    tick();
    b_l.BD = 1'b0; b_l.ExcValid = 1'b0; b_l.ExcCode = 5'd0; b_l.WE = 1'b0;
    b_l.A1 = 5'd13;
    exp_q.push_back(32'h0000_301C); exp_q.push_back(32'h8000_0400); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.EPC !== exp_v) begin
      n_fail++; $display("FAIL sim_epc got %h expected %h", b_l.EPC, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL sim_cause got %h expected %h", b_l.RD, exp_v);
    end
  endtask

  task automatic test_no_bypass();
    b_l.WE = 1'b1; b_l.A2 = 5'd14; b_l.WD = 32'h0000_1237; b_l.A1 = 5'd14;
    exp_q.push_back(32'h0000_301C); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL nobypass_rd got %h expected %h", b_l.RD, exp_v);
    end
    tick();
    b_l.WE = 1'b0;
    exp_q.push_back(32'h0000_1234); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.EPC !== exp_v) begin
      n_fail++; $display("FAIL mtc0_epc got %h expected %h", b_l.EPC, exp_v);
    end
  endtask

  task automatic test_reset_mid_handler();
    rst = 1'b1;
    tick();
    rst = 1'b0; b_l.HWInt = 6'h00; b_l.A1 = 5'd12;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL midrst_sr got %h expected %h", b_l.RD, exp_v);
    end
    b_l.A1 = 5'd13; #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL midrst_cause got %h expected %h", b_l.RD, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.EPC !== exp_v) begin
      n_fail++; $display("FAIL midrst_epc got %h expected %h", b_l.EPC, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL midrst_req got %b expected %h", b_l.Req, exp_v);
    end
  endtask

  task automatic test_exception_wrap();
    b_l.ExcValid = 1'b1; b_l.ExcCode = 5'd8; b_l.PC = 32'h0; b_l.BD = 1'b1;
    exp_q.push_back(32'h1); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL exc_req got %b expected %h", b_l.Req, exp_v);
    end
    tick();
    b_l.A1 = 5'd13;
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h8000_0020); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_l.Req} !== exp_v) begin
      n_fail++; $display("FAIL exc_masked_in_handler got %b expected %h", b_l.Req, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.EPC !== exp_v) begin
      n_fail++; $display("FAIL exc_epc_wrap got %h expected %h", b_l.EPC, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_l.RD !== exp_v) begin
      n_fail++; $display("FAIL exc_cause got %h expected %h", b_l.RD, exp_v);
    end
    b_l.ExcValid = 1'b0; b_l.BD = 1'b0;
  endtask

  task automatic test_edge_mode();
    b_e.A1 = 5'd13; b_e.A2 = 5'd13;
    b_e.HWInt = 6'h04; tick(); b_e.HWInt = 6'h00; tick();
    exp_q.push_back(32'h0000_1000); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_e.RD !== exp_v) begin
      n_fail++; $display("FAIL edge_latch got %h expected %h", b_e.RD, exp_v);
    end
    tick();
    exp_q.push_back(32'h0000_1000); exp_q.push_back(32'h0); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_e.RD !== exp_v) begin
      n_fail++; $display("FAIL edge_sticky got %h expected %h", b_e.RD, exp_v);
    end
    exp_v = exp_q.pop_front(); n_checks++;
    if ({31'b0, b_e.Req} !== exp_v) begin
      n_fail++; $display("FAIL edge_req_ie0 got %b expected %h", b_e.Req, exp_v);
    end
    b_e.WE = 1'b1; b_e.WD = 32'hFFFF_FFFF; tick(); b_e.WE = 1'b0;
    exp_q.push_back(32'h0000_1000); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_e.RD !== exp_v) begin
      n_fail++; $display("FAIL edge_write1_noset got %h expected %h", b_e.RD, exp_v);
    end
    b_e.WE = 1'b1; b_e.WD = 32'h0; tick(); b_e.WE = 1'b0;
    exp_q.push_back(32'h0); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_e.RD !== exp_v) begin
      n_fail++; $display("FAIL edge_clear got %h expected %h", b_e.RD, exp_v);
    end
    b_e.WE = 1'b1; b_e.WD = 32'h0; b_e.HWInt = 6'h04; tick();
    b_e.WE = 1'b0; b_e.HWInt = 6'h00;
    exp_q.push_back(32'h0000_1000); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_e.RD !== exp_v) begin
      n_fail++; $display("FAIL edge_set_beats_clear got %h expected %h", b_e.RD, exp_v);
    end
    b_e.HWInt = 6'h04; tick();
    b_e.WE = 1'b1; b_e.WD = 32'h0; tick(); b_e.WE = 1'b0;
    exp_q.push_back(32'h0); #1;
    exp_v = exp_q.pop_front(); n_checks++;
    if (b_e.RD !== exp_v) begin
      n_fail++; $display("FAIL edge_held_no_reset got %h expected %h", b_e.RD, exp_v);
    end
    b_e.HWInt = 6'h00;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_level_irq();
    test_eret();
    test_simultaneous();
    test_no_bypass();
    test_reset_mid_handler();
    test_exception_wrap();
    test_edge_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/cp0_irq_unit.md
Name: cp0_irq_unit

Overview:
- Parametrised coprocessor-0 / interrupt controller for the pipelined MIPS core.
- Generalises the fixed 6-line HWInt[7:2] interface to NUM_HWINT channels.
- Adds a selectable level or edge-latched pending mode, plus SR/Cause/EPC/PRId registers for mfc0, mtc0 and eret.
- Sits at the M stage: it takes the victim PC and the exception code from the datapath, and returns the interrupt/exception request and the EPC.

Parameters:
- NUM_HWINT, 6, number of hardware interrupt lines, 1..6. They map to Cause.IP / SR.IM bits [10 +: NUM_HWINT].
- INT_LATCH, 0, 0 = level mode (IP follows HWInt); 1 = edge mode (sticky pending bits, cleared by software).
- PRID, 32'h2019_0701, constant value returned for PRId (reg 15).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- A1  in  5  mfc0 read register number.
- RD  out  32  combinational read data for A1.
- A2  in  5  mtc0 write register number.
- WD  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- PC  in  32  PC of the instruction currently in M.
- BD  in  1  the M instruction is in a branch delay slot.
- ExcValid  in  1  synchronous exception pending for the M instruction.
- ExcCode  in  5  code accompanying ExcValid.
- EXLClr  in  1  eret retiring in M.
- HWInt  in  NUM_HWINT  external interrupt lines.
- Req  out  1  take interrupt/exception this cycle; flush and redirect to the handler.
- EPC  out  32  current EPC register.

Behaviour:
- Reset (synchronous, active-high) clears:
  - SR, so IE=0, EXL=0, IM=0.
  - Cause, so BD=0, IP=0, ExcCode=0.
  - EPC, so EPC=0.
  - The edge-detect history.
- Req is 0 from the first cycle after reset.
- Register layout:
  - SR (12): IM at [10 +: N], EXL at bit 1, IE at bit 0; all other bits read 0.
  - Cause (13): BD at bit 31, IP at [10 +: N], ExcCode at [6:2]; all other bits read 0.
  - EPC (14): bits [1:0] always 0.
  - PRId (15): reads PRID.
  - Any other A1 reads 0.
- IntReq = IE & ~EXL & |(IP & IM).
- ExcReq = ExcValid & ~EXL.
- Req = IntReq | ExcReq, combinational, same cycle.
- IP update:
  - INT_LATCH=0: IP is registered each cycle from HWInt, i.e. 1-cycle latency from HWInt to IntReq.
  - INT_LATCH=1: prev <= HWInt each cycle. IP <= (IP & ~clr) | (HWInt & ~prev), where clr comes from an mtc0 Cause write with a 0 in that bit. A new edge in the same cycle as a clear wins (bit stays 1).
- State machine, two states:
  - NORMAL (EXL=0) -> HANDLER (EXL=1) on Req.
  - HANDLER -> NORMAL on EXLClr.
  - In HANDLER, Req is forced 0 regardless of HWInt or ExcValid.
- Entry actions on a Req cycle:
  - EXL <= 1.
  - Cause.BD <= BD.
  - EPC <= (BD ? PC-4 : PC) with [1:0] zeroed; 32-bit wrap on PC-4 (PC=0 gives 32'hFFFF_FFFC).
  - Cause.ExcCode <= IntReq ? 0 : ExcCode. Interrupt has priority over a simultaneous exception.
- Write priority per register:
  - Reset first, then exception entry, then EXLClr, then mtc0.
  - An mtc0 in a Req cycle is discarded entirely.
  - An mtc0 to SR in an EXLClr cycle writes IE/IM, but EXL ends at 0.
- mtc0 write masks:
  - SR: IM, EXL and IE are writable.
  - Cause: only IP is writable, and only when INT_LATCH=1 (clear-by-zero; writing 1 does not set a bit). All Cause bits are read-only when INT_LATCH=0.
  - EPC: fully writable, [1:0] forced 0.
  - PRId and unmapped registers: writes ignored.
- RD has no internal bypass. A read of a register written in the same cycle returns the old value; the hazard unit stalls or forwards.
- The EPC output shows the register value. The new value is visible the cycle after entry or mtc0.

Test Plan:
- Reset: hold Reset 1 for 2 cycles with HWInt all 1s -> RD at A1=12, 13 and 14 returns 0; PRId (A1=15) returns 32'h2019_0701; Req=0.
- Level interrupt: mtc0 SR=32'h0000_0401; raise HWInt[0].
  - Req=1 one cycle later with PC=32'h0000_3010, BD=0.
  - Next cycle: EPC=32'h0000_3010, Cause.ExcCode=0, EXL=1, Req=0.
- Simultaneous events in delay slot: IntReq and ExcValid (ExcCode=5'd12) in the same cycle, BD=1, PC=32'h0000_3020.
  - EPC=32'h0000_301C, Cause=32'h8000_0400 (BD set, IP[0] set, ExcCode 0).
  - A concurrent mtc0 EPC=32'h1234 is discarded.
- eret: EXLClr with HWInt still high and IE=1 -> EXL=0 next cycle; Req re-asserts the following cycle (level mode).
- Edge mode (INT_LATCH=1):
  - 1-cycle pulse on HWInt[2] -> Cause.IP[12]=1 persists after the pulse.
  - mtc0 Cause=0 clears it.
  - A pulse arriving in the same cycle as the clear -> bit stays 1.
- Reset mid-handler: Reset while EXL=1 and EPC nonzero -> next cycle SR=0, Cause=0, EPC=0, Req=0.
